// File: rtl/tdc_frame_acc_if.sv
// Converter-code input and frame-result output bundle for tdc_frame_acc.
// master = code source / result consumer side, slave = the accumulator.
interface tdc_frame_acc_if #(
  parameter int unsigned N_BIT = 2,
  parameter int unsigned ACC_W = 12,
  parameter int unsigned LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic [N_BIT-1:0] code_in;
  logic             code_valid;
  logic [ACC_W-1:0] acc_out;
  logic             acc_sat;
  logic             acc_valid;
  logic             acc_ready;
  logic             busy;
  logic             drop;

  modport master (
    output start, frame_len, code_in, code_valid, acc_ready,
    input  acc_out, acc_sat, acc_valid, busy, drop
  );

  modport slave (
    input  start, frame_len, code_in, code_valid, acc_ready,
    output acc_out, acc_sat, acc_valid, busy, drop
  );
endinterface

// File: rtl/tdc_frame_acc.sv
// Sums frame_len converter codes per frame into a saturating partial sum; result 1 cycle after last code.
// One-entry output register; if it is still full at frame end the sum parks in HOLD and new codes are dropped.
module tdc_frame_acc #(
  parameter int unsigned N_BIT = 2,
  parameter int unsigned ACC_W = 12,
  parameter int unsigned LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  tdc_frame_acc_if.slave    bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam int unsigned SUM_W = ACC_W + 1;

  logic [1:0]       state, state_nxt;
  logic [ACC_W-1:0] acc, out_acc;
  logic [LEN_W-1:0] cnt, len;
  logic             sat, out_sat, out_vld, drop_q;

  logic             take_start, take_code, fire, out_free, last;
  logic [ACC_W-1:0] base_acc, acc_sum;
  logic [LEN_W-1:0] base_cnt, base_len, start_len;
  logic             base_sat, sat_sum;
  logic [SUM_W-1:0] sum_wide;

  // A start in HOLD is ignored so the parked result can never be lost.
  assign take_start = bus.start && (state != ST_HOLD);
  assign take_code  = bus.code_valid && (take_start || (state == ST_ACC));
  assign fire       = out_vld && bus.acc_ready;
  assign out_free   = !out_vld || bus.acc_ready;
  assign start_len  = (bus.frame_len == '0) ? LEN_W'(1) : bus.frame_len;

  always_comb begin
    base_acc = take_start ? '0        : acc;
    base_cnt = take_start ? '0        : cnt;
    base_sat = take_start ? 1'b0      : sat;
    base_len = take_start ? start_len : len;
    sum_wide = {1'b0, base_acc} + SUM_W'(bus.code_in);
    acc_sum  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    sat_sum  = base_sat | sum_wide[ACC_W];
    last     = (base_cnt == base_len - LEN_W'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ACC: begin
        if (take_start) state_nxt = ST_ACC;
        if (take_code && last) state_nxt = out_free ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: if (fire) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      len     <= '0;
      sat     <= 1'b0;
      out_acc <= '0;
      out_sat <= 1'b0;
      out_vld <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      drop_q <= bus.code_valid && !take_code;
      if (fire) out_vld <= 1'b0;
      if (take_start) begin
        acc <= '0;
        cnt <= '0;
        sat <= 1'b0;
        len <= start_len;
      end
      if (take_code) begin
        acc <= acc_sum;
        sat <= sat_sum;
        cnt <= base_cnt + LEN_W'(1);
        if (last && out_free) begin
          out_acc <= acc_sum;
          out_sat <= sat_sum;
          out_vld <= 1'b1;
        end
      end
      // Parked sum moves into the register on the same edge the old result leaves.
      if ((state == ST_HOLD) && fire) begin
        out_acc <= acc;
        out_sat <= sat;
        out_vld <= 1'b1;
      end
    end
  end

  assign bus.acc_out   = out_acc;
  assign bus.acc_sat   = out_sat;
  assign bus.acc_valid = out_vld;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.drop      = drop_q;
endmodule
